// File: rtl/axi_lite_dram_slave_if.sv
// AXI-lite bus bundle between an initiator and the DRAM stand-in.
// Signal names follow the AXI channel names used on the bridge.
interface axi_lite_dram_slave_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64
);
    logic              AR_VALID;
    logic [ADDR_W-1:0] AR_ADDR;
    logic              AR_READY;
    logic              R_VALID;
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;
    logic              R_READY;
    logic              AW_VALID;
    logic [ADDR_W-1:0] AW_ADDR;
    logic              AW_READY;
    logic              W_VALID;
    logic [DATA_W-1:0] W_DATA;
    logic              W_READY;
    logic              B_VALID;
    logic [1:0]        B_RESP;
    logic              B_READY;

    modport slave (
        input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
        output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
    );

    modport master (
        output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
        input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
    );
endinterface

// File: rtl/axi_lite_dram_slave.sv
// Single-beat AXI-lite responder holding a DEPTH x DATA_W word array.
// Reads and writes run on independent FSMs; reads wait RD_LAT extra cycles.
//
// state   | meaning
// RD_IDLE | ready for a read address
// RD_WAIT | counting down read latency, captures data when counter hits 0
// RD_RESP | read data/response presented until R handshake
// WR_IDLE | ready for a write address
// WR_DATA | address latched, waiting for write data
// WR_RESP | write response presented until B handshake
module axi_lite_dram_slave #(
    parameter int                ADDR_W = 17,
    parameter int                DATA_W = 64,
    parameter int                DEPTH  = 256,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(17'h10000),
    parameter int                RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_lite_dram_slave_if.slave   bus
);
    localparam int                IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   LIMIT  = {1'b0, BASE} + (ADDR_W+1)'(8 * DEPTH);
    localparam logic [1:0]        OKAY   = 2'b00;
    localparam logic [1:0]        SLVERR = 2'b10;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    rd_state_t         r_rd_state, w_rd_next;
    wr_state_t         r_wr_state, w_wr_next;
    logic [3:0]        r_rd_cnt;
    logic [IDX_W-1:0]  r_rd_idx, r_wr_idx;
    logic              r_rd_ok, r_wr_ok;
    logic [DATA_W-1:0] r_rd_data;
    logic [1:0]        r_rd_resp, r_wr_resp;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_mem_we;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a >= BASE) && ({1'b0, a} < LIMIT) && (a[2:0] == 3'b000);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 3);
    endfunction

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_rd_state <= RD_IDLE;
        else        r_rd_state <= w_rd_next;
    end

    // Read FSM next-state decode
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (bus.AR_VALID)      w_rd_next = RD_WAIT;
            RD_WAIT: if (r_rd_cnt == 4'd0)  w_rd_next = RD_RESP;
            RD_RESP: if (bus.R_READY)       w_rd_next = RD_IDLE;
            default:                        w_rd_next = RD_IDLE;
        endcase
    end

    // Read datapath: latch address, count latency, capture data before same-edge writes land
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_cnt  <= '0;
            r_rd_idx  <= '0;
            r_rd_ok   <= 1'b0;
            r_rd_data <= '0;
            r_rd_resp <= OKAY;
        end else begin
            case (r_rd_state)
                RD_IDLE: if (bus.AR_VALID) begin
                    r_rd_idx <= addr_idx(bus.AR_ADDR);
                    r_rd_ok  <= addr_ok(bus.AR_ADDR);
                    r_rd_cnt <= 4'(RD_LAT);
                end
                RD_WAIT: if (r_rd_cnt == 4'd0) begin
                    r_rd_data <= r_rd_ok ? r_mem[r_rd_idx] : '0;
                    r_rd_resp <= r_rd_ok ? OKAY : SLVERR;
                end else begin
                    r_rd_cnt <= r_rd_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_wr_state <= WR_IDLE;
        else        r_wr_state <= w_wr_next;
    end

    // Write FSM next-state decode
    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (bus.AW_VALID) w_wr_next = WR_DATA;
            WR_DATA: if (bus.W_VALID)  w_wr_next = WR_RESP;
            WR_RESP: if (bus.B_READY)  w_wr_next = WR_IDLE;
            default:                   w_wr_next = WR_IDLE;
        endcase
    end

    // Write datapath: latch address on AW, set response on W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_idx  <= '0;
            r_wr_ok   <= 1'b0;
            r_wr_resp <= OKAY;
        end else begin
            case (r_wr_state)
                WR_IDLE: if (bus.AW_VALID) begin
                    r_wr_idx <= addr_idx(bus.AW_ADDR);
                    r_wr_ok  <= addr_ok(bus.AW_ADDR);
                end
                WR_DATA: if (bus.W_VALID) r_wr_resp <= r_wr_ok ? OKAY : SLVERR;
                default: ;
            endcase
        end
    end

    // A reset edge never commits a write, so an abandoned transaction leaves memory intact
    assign w_mem_we = rst_n && (r_wr_state == WR_DATA) && bus.W_VALID && r_wr_ok;

    // Word array; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_wr_idx] <= bus.W_DATA;
    end

    // Outputs come only from state and registers
    always_comb begin
        bus.AR_READY = (r_rd_state == RD_IDLE);
        bus.R_VALID  = (r_rd_state == RD_RESP);
        bus.R_DATA   = r_rd_data;
        bus.R_RESP   = r_rd_resp;
        bus.AW_READY = (r_wr_state == WR_IDLE);
        bus.W_READY  = (r_wr_state == WR_DATA);
        bus.B_VALID  = (r_wr_state == WR_RESP);
        bus.B_RESP   = r_wr_resp;
    end
endmodule

// File: tb/tb_axi_lite_dram_slave.sv
// Bench for axi_lite_dram_slave: directed scenarios plus randomized overlapping
// reads/writes, checked every cycle against a transaction-level memory model.
module tb_axi_lite_dram_slave;
    localparam int          ADDR_W = 17;
    localparam int          DATA_W = 64;
    localparam int          DEPTH  = 256;
    localparam int          RD_LAT = 2;
    localparam logic [16:0] BASE   = 17'h10000;
    localparam int          TMO    = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_dram_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    axi_lite_dram_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;
    int cyc = 0;

    // Transaction-level model
    logic [63:0] m_mem [DEPTH];
    bit          m_rd_busy, m_rv, m_aw_have, m_b_pend;
    int          m_rd_due;
    logic [16:0] m_rd_addr, m_wr_addr;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp, m_bresp;

    function automatic bit in_range(input logic [16:0] a);
        int ia;
        ia = int'(a);
        return (ia >= 'h10000) && (ia < 'h10000 + 8 * DEPTH) && (ia % 8 == 0);
    endfunction

    function automatic int word_of(input logic [16:0] a);
        return (int'(a) - 'h10000) / 8;
    endfunction

    task automatic model_step();
        cyc++;
        if (!rst_n) begin
            m_rd_busy = 0; m_rv = 0; m_rdata = '0; m_rresp = 2'b00;
            m_aw_have = 0; m_b_pend = 0; m_bresp = 2'b00;
        end else begin
            // read side first: it sees memory before this edge's write
            if (!m_rd_busy) begin
                if (bus.AR_VALID) begin
                    m_rd_busy = 1; m_rd_addr = bus.AR_ADDR; m_rd_due = cyc + RD_LAT + 1;
                end
            end else if (!m_rv) begin
                if (cyc == m_rd_due) begin
                    m_rv = 1;
                    if (in_range(m_rd_addr)) begin
                        m_rdata = m_mem[word_of(m_rd_addr)]; m_rresp = 2'b00;
                    end else begin
                        m_rdata = '0; m_rresp = 2'b10;
                    end
                end
            end else if (bus.R_READY) begin
                m_rv = 0; m_rd_busy = 0;
            end
            if (!m_aw_have && !m_b_pend) begin
                if (bus.AW_VALID) begin
                    m_aw_have = 1; m_wr_addr = bus.AW_ADDR;
                end
            end else if (m_aw_have) begin
                if (bus.W_VALID) begin
                    if (in_range(m_wr_addr)) begin
                        m_mem[word_of(m_wr_addr)] = bus.W_DATA; m_bresp = 2'b00;
                    end else begin
                        m_bresp = 2'b10;
                    end
                    m_aw_have = 0; m_b_pend = 1;
                end
            end else if (bus.B_READY) begin
                m_b_pend = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s: no handshake within %0d cycles (cycle %0d)", name, TMO, cyc);
    endtask

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("AR_READY", 64'(bus.AR_READY), 64'(!m_rd_busy));
            chk("R_VALID",  64'(bus.R_VALID),  64'(m_rv));
            chk("R_DATA",   bus.R_DATA,        m_rdata);
            chk("R_RESP",   64'(bus.R_RESP),   64'(m_rresp));
            chk("AW_READY", 64'(bus.AW_READY), 64'(!m_aw_have && !m_b_pend));
            chk("W_READY",  64'(bus.W_READY),  64'(m_aw_have));
            chk("B_VALID",  64'(bus.B_VALID),  64'(m_b_pend));
            chk("B_RESP",   64'(bus.B_RESP),   64'(m_bresp));
        end
    end

    // Called and returns at a negedge
    task automatic rd(input logic [16:0] a, input int hold,
                      output logic [63:0] d, output logic [1:0] rs, output int lat);
        int n;
        d = '0; rs = 2'b11; lat = -1; n = 0;
        bus.AR_VALID = 1; bus.AR_ADDR = a;
        while (!bus.AR_READY && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin tmo("AR"); bus.AR_VALID = 0; return; end
        @(negedge clk);
        bus.AR_VALID = 0;
        lat = 0;
        while (!bus.R_VALID && lat < TMO) begin @(negedge clk); lat++; end
        if (lat >= TMO) begin tmo("R"); return; end
        d = bus.R_DATA; rs = bus.R_RESP;
        repeat (hold) @(negedge clk);
        bus.R_READY = 1;
        @(negedge clk);
        bus.R_READY = 0;
    endtask

    task automatic wr(input logic [16:0] a, input logic [63:0] d, input int w_early,
                      input bit b_early, input int hold, output logic [1:0] br);
        int n;
        br = 2'b11;
        bus.W_DATA = d;
        if (w_early > 0) begin
            bus.W_VALID = 1;
            repeat (w_early) begin
                @(negedge clk);
                chk("W_READY before AW", 64'(bus.W_READY), 64'd0);
            end
        end
        if (b_early) bus.B_READY = 1;
        bus.AW_VALID = 1; bus.AW_ADDR = a; bus.W_VALID = 1;
        n = 0;
        while (!bus.AW_READY && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin tmo("AW"); bus.AW_VALID = 0; bus.W_VALID = 0; bus.B_READY = 0; return; end
        @(negedge clk);
        bus.AW_VALID = 0;
        n = 0;
        while (!bus.W_READY && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin tmo("W"); bus.W_VALID = 0; bus.B_READY = 0; return; end
        @(negedge clk);
        bus.W_VALID = 0;
        n = 0;
        while (!bus.B_VALID && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin tmo("B"); bus.B_READY = 0; return; end
        br = bus.B_RESP;
        repeat (hold) @(negedge clk);
        bus.B_READY = 1;
        @(negedge clk);
        bus.B_READY = 0;
    endtask

    function automatic logic [16:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      return 17'(32'h10800 + 8 * $urandom_range(0, 100));
        else if (r == 1) return 17'(32'h10000 + 8 * $urandom_range(0, 15) + $urandom_range(1, 7));
        else if (r == 2) return 17'($urandom_range(0, 32'hFFF8));
        else if (r == 3) return 17'(32'h10000 + 8 * $urandom_range(0, DEPTH - 1));
        else             return 17'(32'h10000 + 8 * $urandom_range(0, 15));
    endfunction

    logic [63:0] d, d0;
    logic [1:0]  rs, br;
    int          lat;

    initial begin
        bus.AR_VALID = 0; bus.AR_ADDR = '0; bus.R_READY = 0;
        bus.AW_VALID = 0; bus.AW_ADDR = '0; bus.W_VALID = 0; bus.W_DATA = '0; bus.B_READY = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk_on = 1;
        chk("reset AR_READY", 64'(bus.AR_READY), 64'd1);
        chk("reset AW_READY", 64'(bus.AW_READY), 64'd1);
        chk("reset R_VALID",  64'(bus.R_VALID),  64'd0);
        chk("reset W_READY",  64'(bus.W_READY),  64'd0);
        chk("reset B_VALID",  64'(bus.B_VALID),  64'd0);
        chk("reset R_DATA",   bus.R_DATA,        64'd0);

        for (int i = 0; i < DEPTH; i++)
            wr(17'(32'h10000 + 8 * i), {$urandom, $urandom}, 0, 1, 0, br);

        // write then read back, latency
        wr(17'h10008, 64'hDEADBEEF_01234567, 0, 1, 0, br);
        chk("wr 10008 B_RESP", 64'(br), 64'd0);
        rd(17'h10008, 0, d, rs, lat);
        chk("rd 10008 data", d, 64'hDEADBEEF_01234567);
        chk("rd 10008 resp", 64'(rs), 64'd0);
        chk("rd latency", 64'(lat), 64'd3);

        // last word, out of range, misaligned write
        rd(17'h107F8, 0, d, rs, lat);
        chk("rd last word resp", 64'(rs), 64'd0);
        rd(17'h10800, 0, d, rs, lat);
        chk("rd out-of-range data", d, 64'd0);
        chk("rd out-of-range resp", 64'(rs), 64'd2);
        rd(17'h10000, 0, d0, rs, lat);
        wr(17'h10004, 64'h0BAD_0BAD_0BAD_0BAD, 0, 0, 1, br);
        chk("wr misaligned B_RESP", 64'(br), 64'd2);
        rd(17'h10000, 0, d, rs, lat);
        chk("word 0 unchanged", d, d0);
        rd(17'h10008, 0, d, rs, lat);
        chk("word 1 unchanged", d, 64'hDEADBEEF_01234567);

        // R_READY held off
        rd(17'h10008, 5, d, rs, lat);
        chk("AR_READY after R handshake", 64'(bus.AR_READY), 64'd1);

        // same-edge collision: W handshake lands on the capture edge
        wr(17'h10010, 64'h1, 0, 1, 0, br);
        bus.AW_VALID = 1; bus.AW_ADDR = 17'h10010; bus.W_DATA = 64'h2;
        @(negedge clk);
        bus.AW_VALID = 0;
        bus.AR_VALID = 1; bus.AR_ADDR = 17'h10010;
        @(negedge clk);
        bus.AR_VALID = 0;
        repeat (2) @(negedge clk);
        bus.W_VALID = 1;
        @(negedge clk);
        bus.W_VALID = 0;
        chk("collision R_VALID", 64'(bus.R_VALID), 64'd1);
        chk("collision old data", bus.R_DATA, 64'h1);
        bus.R_READY = 1; bus.B_READY = 1;
        @(negedge clk);
        bus.R_READY = 0; bus.B_READY = 0;
        rd(17'h10010, 0, d, rs, lat);
        chk("after collision new data", d, 64'h2);

        // W_VALID early
        wr(17'h10018, 64'hCAFE_F00D_1234_5678, 2, 0, 1, br);
        chk("early W B_RESP", 64'(br), 64'd0);
        rd(17'h10018, 0, d, rs, lat);
        chk("early W data", d, 64'hCAFE_F00D_1234_5678);

        // reset mid-transaction
        wr(17'h10020, 64'h5555_AAAA_5555_AAAA, 0, 1, 0, br);
        bus.AR_VALID = 1; bus.AR_ADDR = 17'h10020;
        bus.AW_VALID = 1; bus.AW_ADDR = 17'h10020;
        @(negedge clk);
        bus.AR_VALID = 0; bus.AW_VALID = 0;
        bus.W_VALID = 1; bus.W_DATA = 64'h0123_4567_89AB_CDEF;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1; bus.W_VALID = 0;
        chk("mid-rst AR_READY", 64'(bus.AR_READY), 64'd1);
        chk("mid-rst AW_READY", 64'(bus.AW_READY), 64'd1);
        chk("mid-rst W_READY",  64'(bus.W_READY),  64'd0);
        chk("mid-rst R_VALID",  64'(bus.R_VALID),  64'd0);
        chk("mid-rst B_VALID",  64'(bus.B_VALID),  64'd0);
        rd(17'h10020, 0, d, rs, lat);
        chk("mid-rst memory kept", d, 64'h5555_AAAA_5555_AAAA);

        // randomized overlapping traffic
        fork
            begin : rd_loop
                logic [63:0] rd_d;
                logic [1:0]  rd_rs;
                int          rd_lat;
                for (int i = 0; i < 150; i++) begin
                    rd(pick_addr(), $urandom_range(0, 3), rd_d, rd_rs, rd_lat);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin : wr_loop
                logic [1:0] wr_br;
                for (int i = 0; i < 150; i++) begin
                    wr(pick_addr(), {$urandom, $urandom}, $urandom_range(0, 2),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), wr_br);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
